mult_block_buffer: RTL and testbench
====================================

Name: mult_block_buffer

Overview:
- Parametrised successor of the single-width multiply-to-memory block.
- Accepts operand pairs under a valid/ready handshake and multiplies them in a fixed 3-stage pipeline built from half-width partial products.
- Writes each product to an external block memory at sequential addresses. When the block is full, or flushed early, it streams the stored products back out on demand.
- Sits between the operand source and the single-port product memory.

Parameters:
- OP_WIDTH, 16, operand width in bits; must be even and >= 4.
- LOGDEPTH, 6, log2 of memory depth; DEPTH = 2**LOGDEPTH entries.
- WIDTH, 2*OP_WIDTH, product and memory word width. Localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- EN_mult  in  1  operand pair valid.
- RDY_mult  out  1  block can accept an operand pair.
- mult_input0  in  OP_WIDTH  operand A.
- mult_input1  in  OP_WIDTH  operand B.
- EN_flush  in  1  close a partial block.
- EN_writeMem  out  1  memory write strobe.
- writeMem_addr  out  LOGDEPTH  write address.
- writeMem_val  out  WIDTH  write data.
- EN_blockRead  in  1  request drain of a stored block.
- EN_readMem  out  1  memory read strobe.
- readMem_addr  out  LOGDEPTH  read address.
- readMem_val  in  WIDTH  memory read data; memory has 1-cycle read latency.
- VALID_memVal  out  1  memVal_data valid.
- memVal_data  out  WIDTH  drained product.
- block_count  out  LOGDEPTH+1  entries in the current block.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters 0; pipeline valids cleared. Every output is 0, including RDY_mult.
- RDY_mult is registered and rises on the first clk edge after reset release.
- Accept condition: EN_mult && RDY_mult on a rising edge. Operands are captured into stage 1 as four (OP_WIDTH/2)-bit partial products.
- Pipeline:
  - Stage 2 sums the partial products with shifts of 0, OP_WIDTH/2 (twice) and OP_WIDTH into WIDTH bits.
  - Stage 3 registers the sum to writeMem_val.
  - A valid bit travels with each pair. EN_writeMem is high exactly 3 cycles after accept, for one cycle per accepted pair.
  - Back-to-back accepts give back-to-back writes.
  - Products are unsigned and exact; no truncation, because WIDTH = 2*OP_WIDTH.
- Counters:
  - issued counts accepts; written counts writes; both LOGDEPTH+1 bits.
  - writeMem_addr = written[LOGDEPTH-1:0] at each write, so the first write goes to address 0.
- States:
  - IDLE: RDY_mult=1. An accept moves to FILL. EN_flush and EN_blockRead are ignored.
  - FILL: RDY_mult = (issued < DEPTH) && !flush_pending.
    - When written reaches DEPTH, go to FULL.
    - EN_flush sets flush_pending. Once the pipeline is empty, go to FULL with block_count = written.
    - If EN_flush arrives in the same cycle as an accept, that pair is included in the block.
    - EN_flush with written == DEPTH is redundant; it is harmless.
  - FULL: RDY_mult=0; block_count holds. EN_blockRead moves to DRAIN.
  - DRAIN:
    - EN_readMem=1 with readMem_addr = 0 .. block_count-1, one address per cycle.
    - VALID_memVal is EN_readMem delayed 1 cycle. memVal_data passes readMem_val through combinationally.
    - After the last VALID_memVal, go to IDLE; issued, written, block_count and flush_pending clear to 0.
    - EN_mult is ignored throughout DRAIN.
- Addresses never wrap within a block. A full block ends at address DEPTH-1. block_count = DEPTH is representable.
- A reset mid-FILL or mid-DRAIN aborts immediately: in-flight products are discarded and no write strobe is issued.
- EN_writeMem and EN_readMem are never high in the same cycle.

Optional Feature:
- MULT_BLOCK_SIGNED_EN defined:
  - Adds input port mult_signed (1 bit), sampled with the operands and carried down the pipeline.
  - When mult_signed is 1, operands are two's complement. The product is the exact signed WIDTH-bit result: the upper partial products are sign-extended and the sum is computed in signed arithmetic.
- Undefined: the port is absent and all multiplies are unsigned.

Decomposition:
- Package mult_block_pkg holds:
  - the state enum mbb_state_t {IDLE, FILL, FULL, DRAIN} (2 bits);
  - localparam MULT_PIPE_LAT = 3;
  - a function computing the split partial-product sum for a given OP_WIDTH.
- One sub-module, mult_pipe: the 3-stage multiplier with valid (and signed) sideband, parametrised by OP_WIDTH.

Test Plan:
- Reset release, then one accept of 0x0003 x 0x0005: EN_writeMem high 3 cycles later, addr 0, writeMem_val 0x0000000F. RDY_mult is 0 during reset and 1 after.
- 64 back-to-back accepts of (i, 0xFFFF): writes to addresses 0..63 in consecutive cycles with value i*0xFFFF. RDY_mult drops after accept 64; FULL is reached, block_count = 64.
- FULL, then EN_blockRead pulse: readMem_addr 0..63 on 64 consecutive cycles; VALID_memVal lags by 1 and memVal_data matches the memory model; state returns to IDLE with busy 0.
- 5 accepts, then EN_flush in the same cycle as the 5th: exactly 5 writes, block_count = 5, and the drain reads addresses 0..4 only.
- Assert rst_n low 2 cycles after accepting 0xFFFF x 0xFFFF: no EN_writeMem pulse follows, all outputs are 0 immediately, and the next accept writes to addr 0.
- With MULT_BLOCK_SIGNED_EN and mult_signed = 1, 0xFFFF x 0x0002 -> 0xFFFFFFFE; with mult_signed = 0 -> 0x0001FFFE.

Source files
------------

// File: rtl/mult_block_pkg.sv
// ----------------------------------------------------------------------------
// mult_block_pkg : shared types, constants and partial-product sum helper
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package mult_block_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } mbb_state_t;

  localparam int MULT_PIPE_LAT = 3;

  // Wide enough for OP_WIDTH up to 64; callers sign/zero-extend into it and keep the low WIDTH bits.
  localparam int MBB_SUM_W = 136;

  function automatic logic [MBB_SUM_W-1:0] mbb_pp_sum(
    input logic [MBB_SUM_W-1:0] ll,
    input logic [MBB_SUM_W-1:0] lh,
    input logic [MBB_SUM_W-1:0] hl,
    input logic [MBB_SUM_W-1:0] hh,
    input int unsigned          half
  );
    return ll + (lh << half) + (hl << half) + (hh << (2 * half));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_block_buffer_pipe.sv
// ----------------------------------------------------------------------------
// mult_pipe : 3-stage half-width partial-product multiplier with valid/sign sideband
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mult_pipe
  import mult_block_pkg::*;
#(
  parameter int OP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_signed,
  input  logic [OP_WIDTH-1:0]     a,
  input  logic [OP_WIDTH-1:0]     b,
  output logic                    out_valid,
  output logic [2*OP_WIDTH-1:0]   out_prod
);

  localparam int HALF  = OP_WIDTH / 2;
  localparam int WIDTH = 2 * OP_WIDTH;
  localparam int PPW   = OP_WIDTH + 2;
  localparam int EXT   = MBB_SUM_W - PPW;

  // Upper halves carry the operand sign in signed mode; lower halves are always unsigned.
  logic [PPW-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  assign w_a_lo = {{(HALF+2){1'b0}}, a[HALF-1:0]};
  assign w_b_lo = {{(HALF+2){1'b0}}, b[HALF-1:0]};
  assign w_a_hi = {{(HALF+2){in_signed & a[OP_WIDTH-1]}}, a[OP_WIDTH-1:HALF]};
  assign w_b_hi = {{(HALF+2){in_signed & b[OP_WIDTH-1]}}, b[OP_WIDTH-1:HALF]};

  logic [PPW-1:0] r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
  logic           r_v1, r_s1;
  logic [WIDTH-1:0] r_sum;
  logic           r_v2;
  logic [WIDTH-1:0] r_prod;
  logic           r_v3;

  logic [MBB_SUM_W-1:0] w_ll, w_lh, w_hl, w_hh, w_full;
  assign w_ll = {{EXT{r_s1 & r_pp_ll[PPW-1]}}, r_pp_ll};
  assign w_lh = {{EXT{r_s1 & r_pp_lh[PPW-1]}}, r_pp_lh};
  assign w_hl = {{EXT{r_s1 & r_pp_hl[PPW-1]}}, r_pp_hl};
  assign w_hh = {{EXT{r_s1 & r_pp_hh[PPW-1]}}, r_pp_hh};
  assign w_full = mbb_pp_sum(w_ll, w_lh, w_hl, w_hh, HALF);

  logic w_unused_sum_hi;
  assign w_unused_sum_hi = &{1'b0, w_full[MBB_SUM_W-1:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pp_ll <= '0;
      r_pp_lh <= '0;
      r_pp_hl <= '0;
      r_pp_hh <= '0;
      r_v1    <= 1'b0;
      r_s1    <= 1'b0;
      r_sum   <= '0;
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_v3    <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_pp_ll <= w_a_lo * w_b_lo;
        r_pp_lh <= w_a_lo * w_b_hi;
        r_pp_hl <= w_a_hi * w_b_lo;
        r_pp_hh <= w_a_hi * w_b_hi;
        r_s1    <= in_signed;
      end
      r_v2 <= r_v1;
      if (r_v1) r_sum <= w_full[WIDTH-1:0];
      r_v3 <= r_v2;
      if (r_v2) r_prod <= r_sum;
    end
  end

  assign out_valid = r_v3;
  assign out_prod  = r_prod;

endmodule

`default_nettype wire

// File: rtl/mult_block_buffer.sv
// ----------------------------------------------------------------------------
// mult_block_buffer : multiply operand pairs into a block memory, then drain it
// Optional signed multiply enabled by defining MULT_BLOCK_SIGNED_EN.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mult_block_buffer
  import mult_block_pkg::*;
#(
  parameter int OP_WIDTH = 16,
  parameter int LOGDEPTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     EN_mult,
  output logic                     RDY_mult,
  input  logic [OP_WIDTH-1:0]      mult_input0,
  input  logic [OP_WIDTH-1:0]      mult_input1,
`ifdef MULT_BLOCK_SIGNED_EN
  input  logic                     mult_signed,
`endif
  input  logic                     EN_flush,
  output logic                     EN_writeMem,
  output logic [LOGDEPTH-1:0]      writeMem_addr,
  output logic [2*OP_WIDTH-1:0]    writeMem_val,
  input  logic                     EN_blockRead,
  output logic                     EN_readMem,
  output logic [LOGDEPTH-1:0]      readMem_addr,
  input  logic [2*OP_WIDTH-1:0]    readMem_val,
  output logic                     VALID_memVal,
  output logic [2*OP_WIDTH-1:0]    memVal_data,
  output logic [LOGDEPTH:0]        block_count,
  output logic                     busy
);

  localparam int WIDTH = 2 * OP_WIDTH;
  localparam logic [LOGDEPTH:0] DEPTH_CNT = {1'b1, {LOGDEPTH{1'b0}}};

  mbb_state_t          r_state;
  logic                r_rdy;
  logic [LOGDEPTH:0]   r_issued;
  logic [LOGDEPTH:0]   r_written;
  logic [LOGDEPTH:0]   r_block_count;
  logic                r_flush_pending;
  logic [LOGDEPTH-1:0] r_rd_addr;
  logic                r_en_read;
  logic                r_valid_mem;

  logic                w_sgn;
  logic                w_accept;
  logic                w_pipe_valid;
  logic [WIDTH-1:0]    w_pipe_prod;
  logic [LOGDEPTH:0]   w_issued_nxt;
  logic [LOGDEPTH:0]   w_written_nxt;
  logic                w_flush_nxt;

`ifdef MULT_BLOCK_SIGNED_EN
  assign w_sgn = mult_signed;
`else
  assign w_sgn = 1'b0;
`endif

  assign w_accept      = EN_mult && r_rdy;
  assign w_issued_nxt  = r_issued + (LOGDEPTH+1)'(w_accept);
  assign w_written_nxt = r_written + (LOGDEPTH+1)'(w_pipe_valid);
  assign w_flush_nxt   = r_flush_pending | EN_flush;

  mult_pipe #(
    .OP_WIDTH (OP_WIDTH)
  ) u_mult_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_accept),
    .in_signed (w_sgn),
    .a         (mult_input0),
    .b         (mult_input1),
    .out_valid (w_pipe_valid),
    .out_prod  (w_pipe_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_rdy           <= 1'b0;
      r_issued        <= '0;
      r_written       <= '0;
      r_block_count   <= '0;
      r_flush_pending <= 1'b0;
      r_rd_addr       <= '0;
      r_en_read       <= 1'b0;
      r_valid_mem     <= 1'b0;
    end else begin
      r_valid_mem <= r_en_read;
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_state  <= FILL;
            r_issued <= w_issued_nxt;
          end
        end
        FILL: begin
          r_issued        <= w_issued_nxt;
          r_written       <= w_written_nxt;
          r_block_count   <= w_written_nxt;
          r_flush_pending <= w_flush_nxt;
          // A flush only closes the block once every accepted pair has landed in memory.
          if ((w_written_nxt == DEPTH_CNT) || (w_flush_nxt && (w_issued_nxt == w_written_nxt))) begin
            r_state <= FULL;
            r_rdy   <= 1'b0;
          end else begin
            r_rdy <= (w_issued_nxt < DEPTH_CNT) && !w_flush_nxt;
          end
        end
        FULL: begin
          r_rdy <= 1'b0;
          if (EN_blockRead) begin
            r_state   <= DRAIN;
            r_en_read <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        DRAIN: begin
          r_rdy <= 1'b0;
          if (r_en_read) begin
            if ({1'b0, r_rd_addr} == (r_block_count - (LOGDEPTH+1)'(1))) begin
              r_en_read <= 1'b0;
            end else begin
              r_rd_addr <= r_rd_addr + LOGDEPTH'(1);
            end
          end
          if (r_valid_mem && !r_en_read) begin
            r_state         <= IDLE;
            r_rdy           <= 1'b1;
            r_issued        <= '0;
            r_written       <= '0;
            r_block_count   <= '0;
            r_flush_pending <= 1'b0;
            r_rd_addr       <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RDY_mult      = r_rdy;
  assign EN_writeMem   = w_pipe_valid;
  assign writeMem_addr = r_written[LOGDEPTH-1:0];
  assign writeMem_val  = w_pipe_prod;
  assign EN_readMem    = r_en_read;
  assign readMem_addr  = r_rd_addr;
  assign VALID_memVal  = r_valid_mem;
  assign memVal_data   = r_valid_mem ? readMem_val : '0;
  assign block_count   = r_block_count;
  assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_block_buffer.sv
// ----------------------------------------------------------------------------
// tb_mult_block_buffer : directed bench with a transaction-level reference model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mult_block_buffer;

  localparam int OPW   = 16;
  localparam int LD    = 6;
  localparam int DEPTH = 64;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          EN_mult = 1'b0;
  logic          RDY_mult;
  logic [OPW-1:0] mult_input0 = '0;
  logic [OPW-1:0] mult_input1 = '0;
  logic          EN_flush = 1'b0;
  logic          EN_writeMem;
  logic [LD-1:0] writeMem_addr;
  logic [W-1:0]  writeMem_val;
  logic          EN_blockRead = 1'b0;
  logic          EN_readMem;
  logic [LD-1:0] readMem_addr;
  logic [W-1:0]  readMem_val = '0;
  logic          VALID_memVal;
  logic [W-1:0]  memVal_data;
  logic [LD:0]   block_count;
  logic          busy;
  logic          s_in;
`ifdef MULT_BLOCK_SIGNED_EN
  logic          mult_signed = 1'b0;
  assign s_in = mult_signed;
`else
  assign s_in = 1'b0;
`endif

  always #5 clk = ~clk;

  mult_block_buffer #(.OP_WIDTH(OPW), .LOGDEPTH(LD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EN_mult       (EN_mult),
    .RDY_mult      (RDY_mult),
    .mult_input0   (mult_input0),
    .mult_input1   (mult_input1),
`ifdef MULT_BLOCK_SIGNED_EN
    .mult_signed   (mult_signed),
`endif
    .EN_flush      (EN_flush),
    .EN_writeMem   (EN_writeMem),
    .writeMem_addr (writeMem_addr),
    .writeMem_val  (writeMem_val),
    .EN_blockRead  (EN_blockRead),
    .EN_readMem    (EN_readMem),
    .readMem_addr  (readMem_addr),
    .readMem_val   (readMem_val),
    .VALID_memVal  (VALID_memVal),
    .memVal_data   (memVal_data),
    .block_count   (block_count),
    .busy          (busy)
  );

  // External single-port memory with one-cycle read latency.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem)  readMem_val <= mem[readMem_addr];
  end

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_writes = 0;
  int n_reads  = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] model_prod(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic s);
    longint sa, sb;
    logic [63:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    p = sa * sb;
    return p[W-1:0];
  endfunction

  // Reference model: block-level bookkeeping of the operating modes.
  localparam int M_IDLE = 0, M_FILL = 1, M_FULL = 2, M_DRAIN = 3;
  int          m_mode, m_issued, m_written, m_bc, m_rd_idx, m_prev_addr;
  bit          m_rdy, m_flush, m_prev_read;
  int          q_due[$];
  logic [W-1:0] q_val[$];
  logic [W-1:0] exp_mem [DEPTH];

  task automatic model_reset();
    m_mode = M_IDLE; m_issued = 0; m_written = 0; m_bc = 0; m_rd_idx = 0;
    m_prev_addr = 0; m_rdy = 1'b0; m_flush = 1'b0; m_prev_read = 1'b0;
    q_due.delete();
    q_val.delete();
  endtask

  bit wr_exp, rd_exp, vld_now, acc;
  always @(negedge clk) begin
    cyc++;
    if (EN_writeMem) n_writes++;
    if (EN_readMem)  n_reads++;
    if (!rst_n) begin
      chk("reset_outputs",
          {RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr,
           VALID_memVal, memVal_data, block_count, busy}, 64'd0);
      model_reset();
    end else begin
      wr_exp = (q_due.size() > 0) && (q_due[0] == cyc);
      rd_exp = (m_mode == M_DRAIN) && (m_rd_idx < m_bc);
      chk("rdy", RDY_mult, m_rdy);
      chk("busy", busy, (m_mode != M_IDLE));
      chk("wr_en", EN_writeMem, wr_exp);
      if (wr_exp) begin
        chk("wr_addr", writeMem_addr, m_written);
        chk("wr_val", writeMem_val, q_val[0]);
        exp_mem[m_written] = q_val[0];
        void'(q_due.pop_front());
        void'(q_val.pop_front());
        m_written++;
      end
      chk("rd_en", EN_readMem, rd_exp);
      if (rd_exp) chk("rd_addr", readMem_addr, m_rd_idx);
      chk("mem_valid", VALID_memVal, m_prev_read);
      if (m_prev_read) chk("mem_data", memVal_data, exp_mem[m_prev_addr]);
      if (m_mode != M_FILL) chk("block_count", block_count, (m_mode == M_IDLE) ? 0 : m_bc);

      acc = EN_mult && m_rdy;
      if (acc) begin
        q_due.push_back(cyc + 3);
        q_val.push_back(model_prod(mult_input0, mult_input1, s_in));
        m_issued++;
      end
      case (m_mode)
        M_IDLE: begin
          m_rdy = 1'b1;
          if (acc) m_mode = M_FILL;
        end
        M_FILL: begin
          m_flush = m_flush | EN_flush;
          if (m_written == DEPTH || (m_flush && m_issued == m_written)) begin
            m_mode = M_FULL;
            m_bc   = m_written;
            m_rdy  = 1'b0;
          end else begin
            m_rdy = (m_issued < DEPTH) && !m_flush;
          end
        end
        M_FULL: begin
          if (EN_blockRead) begin
            m_mode   = M_DRAIN;
            m_rd_idx = 0;
          end
        end
        default: begin
          vld_now     = m_prev_read;
          m_prev_read = rd_exp;
          m_prev_addr = m_rd_idx;
          if (rd_exp) m_rd_idx++;
          if (vld_now && !rd_exp) begin
            m_mode = M_IDLE; m_issued = 0; m_written = 0; m_bc = 0;
            m_flush = 1'b0; m_rdy = 1'b1; m_prev_read = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; scans for the resulting write strobe.
  task automatic expect_write(input string nm, input logic [LD-1:0] ea, input logic [W-1:0] ev);
    bit found = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (!found && EN_writeMem) begin
        found = 1'b1;
        chk({nm, "_latency"}, k, 3);
        chk({nm, "_addr"}, writeMem_addr, ea);
        chk({nm, "_val"}, writeMem_val, ev);
      end
    end
    chk({nm, "_seen"}, found, 1);
    tick();
  endtask

  task automatic accept(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    EN_mult = 1'b1; mult_input0 = a; mult_input1 = b;
    tick();
    EN_mult = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic flush_and_drain(input string nm, input int exp_bc);
    int r0;
    EN_flush = 1'b1;
    tick();
    EN_flush = 1'b0;
    repeat (5) tick();
    chk({nm, "_bc"}, block_count, exp_bc);
    r0 = n_reads;
    EN_blockRead = 1'b1;
    tick();
    EN_blockRead = 1'b0;
    wait_idle(nm, 100);
    chk({nm, "_reads"}, n_reads - r0, exp_bc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w0, r0;
    model_reset();
    repeat (3) tick();
    chk("rdy_in_reset", RDY_mult, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_first_edge", RDY_mult, 0);
    tick();
    chk("rdy_after_reset", RDY_mult, 1);

    EN_flush = 1'b1; EN_blockRead = 1'b1;
    tick();
    EN_flush = 1'b0; EN_blockRead = 1'b0;
    tick();
    chk("idle_ignores_flush_read", busy, 0);

    accept(16'h0003, 16'h0005);
    expect_write("first", 6'd0, 32'h0000000F);
    flush_and_drain("single", 1);

    // Full block of 64, with EN_mult held past the point RDY_mult drops.
    w0 = n_writes;
    for (int i = 0; i < DEPTH + 2; i++) begin
      EN_mult = 1'b1; mult_input0 = OPW'(i); mult_input1 = 16'hFFFF;
      tick();
    end
    EN_mult = 1'b0;
    repeat (5) tick();
    chk("full_writes", n_writes - w0, 64);
    chk("full_bc", block_count, 64);
    chk("full_rdy", RDY_mult, 0);
    chk("full_busy", busy, 1);
    chk("mem63", mem[63], 32'h003EFFC1);
    r0 = n_reads;
    EN_blockRead = 1'b1;
    tick();
    EN_blockRead = 1'b0;
    wait_idle("full_drain", 150);
    chk("full_drain_reads", n_reads - r0, 64);

    // Flush in the same cycle as the fifth accept.
    w0 = n_writes;
    for (int i = 0; i < 5; i++) begin
      EN_mult = 1'b1; mult_input0 = OPW'(i + 1); mult_input1 = 16'h1000 + OPW'(i);
      EN_flush = (i == 4);
      tick();
    end
    EN_mult = 1'b0; EN_flush = 1'b0;
    repeat (6) tick();
    chk("five_writes", n_writes - w0, 5);
    chk("five_bc", block_count, 5);
    r0 = n_reads;
    EN_blockRead = 1'b1;
    tick();
    EN_blockRead = 1'b0;
    wait_idle("five_drain", 50);
    chk("five_drain_reads", n_reads - r0, 5);

    // Reset two cycles after an accept discards the in-flight product.
    accept(16'hFFFF, 16'hFFFF);
    tick();
    rst_n = 1'b0;
    w0 = n_writes;
    @(negedge clk);
    chk("rst_async_wr", EN_writeMem, 0);
    chk("rst_async_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_no_write", n_writes - w0, 0);

    accept(16'h0007, 16'h0009);
    expect_write("post_rst", 6'd0, 32'h0000003F);
    accept(16'hFFFF, 16'h0002);
    expect_write("unsigned", 6'd1, 32'h0001FFFE);
`ifdef MULT_BLOCK_SIGNED_EN
    mult_signed = 1'b1;
    accept(16'hFFFF, 16'h0002);
    mult_signed = 1'b0;
    expect_write("signed", 6'd2, 32'hFFFFFFFE);
    flush_and_drain("tail", 3);
`else
    flush_and_drain("tail", 2);
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
